// File: rtl/alu_seq16.sv
// 16-bit operation sequencer: splits a word op into two byte-wide steps on an
// external combinational 8-bit ALU, chaining carry/shift bits between steps.
module alu_seq16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_cin,
  output logic [7:0]  alu_arg_0,
  output logic [7:0]  alu_arg_1,
  output logic [2:0]  alu_op_code,
  output logic        alu_sc_in,
  input  logic [7:0]  alu_out,
  input  logic        alu_sc_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_cout,
  output logic        rsp_zero
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_LSH  = 3'b001;
  localparam logic [OP_W-1:0] OP_RSH  = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_AND  = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
  localparam logic [OP_W-1:0] ALU_NOP = 3'b111;

  typedef enum logic [1:0] {IDLE, STEP1, STEP2, DONE} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   code;
    logic [BYTE_W-1:0] arg_0;
    logic [BYTE_W-1:0] arg_1;
    logic              sc_in;
  } alu_drive_t;

  localparam alu_drive_t IDLE_DRIVE = '{ALU_NOP, 8'h00, 8'h00, 1'b0};

  state_t            state, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WORD_W-1:0] a_q, a_d, b_q, b_d;
  logic              cin_q, cin_d;
  logic [BYTE_W-1:0] first_q, first_d;
  logic              carry_q, carry_d;
  alu_drive_t        drive_q, drive_d;
  logic              req_ready_d;
  logic              rsp_valid_d, rsp_cout_d, rsp_zero_d;
  logic [WORD_W-1:0] rsp_data_d;
  logic [WORD_W-1:0] word;

  // ALU drive for one step; RSH walks high byte first so the shift-out chains downward
  function automatic alu_drive_t step_drive(input logic [OP_W-1:0] op,
                                            input logic [WORD_W-1:0] a,
                                            input logic [WORD_W-1:0] b,
                                            input logic cin,
                                            input logic second,
                                            input logic carry);
    alu_drive_t        d;
    logic              hi;
    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    hi     = (op == OP_RSH) ? ~second : second;
    a_byte = hi ? a[WORD_W-1:BYTE_W] : a[BYTE_W-1:0];
    b_byte = hi ? b[WORD_W-1:BYTE_W] : b[BYTE_W-1:0];
    d      = IDLE_DRIVE;
    case (op)
      OP_ADD:         d = '{OP_ADD, a_byte, b_byte, second ? carry : cin};
      OP_SUB:         d = '{OP_ADD, a_byte, ~b_byte, second ? carry : ~cin};
      OP_LSH, OP_RSH: d = '{op, a_byte, 8'h00, second ? carry : cin};
      OP_XOR, OP_AND: d = '{op, a_byte, b_byte, 1'b0};
      default:        d = IDLE_DRIVE;
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= ALU_NOP;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      first_q   <= '0;
      carry_q   <= 1'b0;
      drive_q   <= IDLE_DRIVE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      first_q   <= first_d;
      carry_q   <= carry_d;
      drive_q   <= drive_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_cout  <= rsp_cout_d;
      rsp_zero  <= rsp_zero_d;
    end
  end

  // Next-state and next-output decode; ALU drive is registered one step ahead
  always_comb begin
    state_d     = state;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    first_d     = first_q;
    carry_d     = carry_q;
    drive_d     = IDLE_DRIVE;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_cout_d  = rsp_cout;
    rsp_zero_d  = rsp_zero;
    word        = (op_q == OP_RSH) ? {first_q, alu_out} : {alu_out, first_q};

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_d = STEP1;
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          cin_d   = req_cin;
          drive_d = step_drive(req_op, req_a, req_b, req_cin, 1'b0, 1'b0);
        end
      end
      STEP1: begin
        state_d = STEP2;
        first_d = alu_out;
        carry_d = alu_sc_out;
        drive_d = step_drive(op_q, a_q, b_q, cin_q, 1'b1, alu_sc_out);
      end
      STEP2: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        case (op_q)
          OP_ADD, OP_SUB, OP_LSH, OP_RSH: begin
            rsp_data_d = word;
            rsp_cout_d = alu_sc_out;
          end
          OP_XOR, OP_AND: begin
            rsp_data_d = word;
            rsp_cout_d = 1'b0;
          end
          default: begin
            rsp_data_d = '0;
            rsp_cout_d = 1'b0;
          end
        endcase
        rsp_zero_d = (rsp_data_d == WORD_W'(0));
      end
      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  assign alu_op_code = drive_q.code;
  assign alu_arg_0   = drive_q.arg_0;
  assign alu_arg_1   = drive_q.arg_1;
  assign alu_sc_in   = drive_q.sc_in;

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: external 8-bit ALU model, word-level reference model,
// per-cycle compare process, directed cases and randomized traffic.
module tb_alu_seq16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [15:0] req_a = 16'h0000;
  logic [15:0] req_b = 16'h0000;
  logic        req_cin = 1'b0;
  logic [7:0]  alu_arg_0, alu_arg_1, alu_out;
  logic [2:0]  alu_op_code;
  logic        alu_sc_in, alu_sc_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_cout, rsp_zero;

  always #5 clk = ~clk;

  alu_seq16 dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_arg_0(alu_arg_0), .alu_arg_1(alu_arg_1), .alu_op_code(alu_op_code),
    .alu_sc_in(alu_sc_in), .alu_out(alu_out), .alu_sc_out(alu_sc_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero)
  );

  // The combinational 8-bit ALU the sequencer drives
  always_comb begin
    alu_out    = 8'h00;
    alu_sc_out = 1'b0;
    case (alu_op_code)
      3'b000: {alu_sc_out, alu_out} = 9'(alu_arg_0) + 9'(alu_arg_1) + 9'(alu_sc_in);
      3'b001: begin alu_out = {alu_arg_0[6:0], alu_sc_in}; alu_sc_out = alu_arg_0[7]; end
      3'b010: begin alu_out = {alu_sc_in, alu_arg_0[7:1]}; alu_sc_out = alu_arg_0[0]; end
      3'b011: alu_out = alu_arg_0 ^ alu_arg_1;
      3'b100: alu_out = alu_arg_0 & alu_arg_1;
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        cout;
    logic        zero;
    logic [2:0]  code;
  } exp_t;

  // Word-level reference: what the 16-bit operation means
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin);
    exp_t e;
    int unsigned s;
    e.data = 16'h0000; e.cout = 1'b0; e.code = 3'b111;
    case (op)
      3'd0: begin s = 32'(a) + 32'(b) + 32'(cin); e.data = s[15:0]; e.cout = s[16]; e.code = 3'd0; end
      3'd5: begin e.data = a - b - 16'(cin); e.cout = (32'(a) >= 32'(b) + 32'(cin)); e.code = 3'd0; end
      3'd1: begin e.data = {a[14:0], cin}; e.cout = a[15]; e.code = 3'd1; end
      3'd2: begin e.data = {cin, a[15:1]}; e.cout = a[0]; e.code = 3'd2; end
      3'd3: begin e.data = a ^ b; e.code = 3'd3; end
      3'd4: begin e.data = a & b; e.code = 3'd4; end
      default: ;
    endcase
    e.zero = (e.data == 16'h0000);
    return e;
  endfunction

  // Per-cycle compare process: phase 0 idle, 1/2 steps, 3 response pending
  exp_t       expq[$];
  int         phase = 0;
  logic [2:0] cur_code = 3'b111;
  exp_t       e_new;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_cout", rsp_cout, 0);
      check("rst_rsp_zero", rsp_zero, 0);
      check("rst_alu_op_code", alu_op_code, 3'b111);
      check("rst_alu_args", {alu_arg_0, alu_arg_1, 7'd0, alu_sc_in}, 0);
      phase = 0;
      expq.delete();
    end else begin
      check("req_ready", req_ready, phase == 0);
      check("rsp_valid", rsp_valid, phase == 3);
      if (phase == 1 || phase == 2)
        check("alu_op_code_step", alu_op_code, cur_code);
      else begin
        check("alu_op_code_idle", alu_op_code, 3'b111);
        check("alu_drive_idle", {alu_arg_0, alu_arg_1, 7'd0, alu_sc_in}, 0);
      end
      if (phase == 3) begin
        check("rsp_pending", expq.size(), 1);
        if (expq.size() > 0) begin
          check("rsp_data", rsp_data, expq[0].data);
          check("rsp_cout", rsp_cout, expq[0].cout);
          check("rsp_zero", rsp_zero, expq[0].zero);
        end
      end
      case (phase)
        0: if (req_valid) begin
             e_new = model(req_op, req_a, req_b, req_cin);
             expq.push_back(e_new);
             cur_code = e_new.code;
             phase = 1;
           end
        1: phase = 2;
        2: phase = 3;
        default: if (rsp_ready) begin
             phase = 0;
             if (expq.size() > 0) void'(expq.pop_front());
           end
      endcase
    end
  end

  // Present a request; returns at the start of STEP1
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic cin);
    int n;
    n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom); req_cin = 1'($urandom);
  endtask

  // Collect a response, optionally stalling rsp_ready for hold cycles
  task automatic recv(input int hold, output logic [15:0] d, output logic c, output logic z);
    int n;
    n = 0;
    rsp_ready = (hold == 0);
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", rsp_valid, 1);
    d = rsp_data; c = rsp_cout; z = rsp_zero;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_data", {15'd0, rsp_cout, rsp_data}, {15'd0, c, d});
        check("hold_req_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  logic [15:0] d;
  logic        c, z;
  logic [2:0]  rop;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // ADD with carry out of the low byte
    send(3'd0, 16'h00FF, 16'h0001, 1'b0);
    check("add_s1_args", {alu_arg_0, alu_arg_1}, 16'hFF01);
    check("add_s1_sc", alu_sc_in, 0);
    @(posedge clk); #1;
    check("add_s2_args", {alu_arg_0, alu_arg_1}, 16'h0000);
    check("add_s2_sc", alu_sc_in, 1);
    recv(0, d, c, z);
    check("add_result", {c, z, d}, {1'b0, 1'b0, 16'h0100});

    // SUB: inverted B byte on arg_1
    send(3'd5, 16'h0100, 16'h0001, 1'b0);
    check("sub_s1_arg1", alu_arg_1, 8'hFE);
    check("sub_s1_sc", alu_sc_in, 1);
    recv(0, d, c, z);
    check("sub_result", {c, d}, {1'b1, 16'h00FF});
    send(3'd5, 16'h0000, 16'h0001, 1'b0);
    recv(0, d, c, z);
    check("sub_borrow", {c, d}, {1'b0, 16'hFFFF});

    // Shifts
    send(3'd1, 16'h80B3, 16'h5555, 1'b1);
    recv(0, d, c, z);
    check("lsh_result", {c, d}, {1'b1, 16'h0167});
    send(3'd2, 16'h0001, 16'h5555, 1'b1);
    check("rsh_s1_hi_byte", alu_arg_0, 8'h00);
    @(posedge clk); #1;
    check("rsh_s2_lo_byte", alu_arg_0, 8'h01);
    recv(0, d, c, z);
    check("rsh_result", {c, d}, {1'b1, 16'h8000});

    // XOR to zero and invalid op
    send(3'd3, 16'h1234, 16'h1234, 1'b1);
    recv(0, d, c, z);
    check("xor_result", {c, z, d}, {1'b0, 1'b1, 16'h0000});
    send(3'd6, 16'hABCD, 16'h1234, 1'b1);
    check("inv_s1_code", alu_op_code, 3'b111);
    recv(0, d, c, z);
    check("inv_result", {c, z, d}, {1'b0, 1'b1, 16'h0000});

    // Back-pressure with a pending request
    send(3'd4, 16'hF0F0, 16'h3C3C, 1'b0);
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'h1234; req_b = 16'h1111; req_cin = 1'b1;
    recv(5, d, c, z);
    check("and_result", {c, z, d}, {1'b0, 1'b0, 16'h3030});
    send(3'd0, 16'h1234, 16'h1111, 1'b1);
    recv(0, d, c, z);
    check("pending_add_result", d, 16'h2346);

    // Reset during STEP2 discards the operation
    send(3'd0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_async_valid", rsp_valid, 0);
    check("rst_async_code", alu_op_code, 3'b111);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    send(3'd0, 16'h7FFF, 16'h0001, 1'b0);
    recv(0, d, c, z);
    check("post_rst_add", {c, d}, {1'b0, 16'h8000});

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      rop = 3'($urandom_range(0, 7));
      send(rop, 16'($urandom), 16'($urandom), 1'($urandom));
      recv(int'($urandom_range(0, 3)), d, c, z);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
